// File: rtl/fsk_rx_frame_ctrl.sv
// Frame receive controller: assembles SYNC, LEN, payload, CHK from byte-receiver events.
// Latency: every byte event becomes visible on the outputs one clk later.
// Backpressure: none. Payload writes are fire-and-forget, and a stalled frame is dropped by the inter-byte timeout.
module fsk_rx_frame_ctrl #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         AW      = 4,
    parameter int         TO_CYC  = 500000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_rx_byte,
    input  logic [7:0]    RX_dat,
    input  logic          OCD,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_dat,
    output logic [7:0]    rx_len,
    output logic          busy,
    output logic          frame_ok,
    output logic          frame_err,
    output logic [1:0]    err_code
);
    localparam int            TW        = $clog2(TO_CYC);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, GET_LEN, GET_DATA, GET_CHK} state_t;

    state_t          state_q, state_d;
    logic            en_d_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      rx_len_q, rx_len_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_dat_q, wr_dat_d;
    logic            busy_q, busy_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            byte_done;

    // The byte receiver drops en_rx_byte once RX_dat is valid.
    assign byte_done = en_d_q & ~en_rx_byte;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        rx_len_d    = rx_len_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_dat_d    = wr_dat_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        if (state_q != IDLE) begin
            timer_d = byte_done ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (byte_done && RX_dat == SYNC && OCD) begin
                    state_d = GET_LEN;
                    timer_d = '0;
                end
            end
            GET_LEN: begin
                if (byte_done) begin
                    if (RX_dat == 8'd0 || RX_dat > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = IDLE;
                    end else begin
                        rx_len_d = RX_dat;
                        sum_d    = RX_dat;
                        idx_d    = 8'd0;
                        state_d  = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (byte_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[AW-1:0];
                    wr_dat_d  = RX_dat;
                    idx_d     = idx_q + 8'd1;
                    sum_d     = sum_q + RX_dat;
                    if (idx_q == rx_len_q - 8'd1) begin
                        state_d = GET_CHK;
                    end
                end
            end
            GET_CHK: begin
                if (byte_done) begin
                    if (RX_dat == sum_q) begin
                        frame_ok_d = 1'b1;
                        err_code_d = 2'd0;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte landing on the terminal count wins over the timeout.
        if (state_q != IDLE && !byte_done && timer_q == TO_LAST) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = IDLE;
            timer_d     = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_d_q      <= 1'b0;
            timer_q     <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            rx_len_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_dat_q    <= '0;
            busy_q      <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            en_d_q      <= en_rx_byte;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            rx_len_q    <= rx_len_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_dat_q    <= wr_dat_d;
            busy_q      <= busy_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_dat    = wr_dat_q;
    assign rx_len    = rx_len_q;
    assign busy      = busy_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_fsk_rx_frame_ctrl.sv
// Bench for fsk_rx_frame_ctrl: directed frames from the test plan plus randomized frames
// checked against a frame-level model (expected writes, outcome pulses, held code and length).
module tb_fsk_rx_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       en_rx_byte;
    logic [7:0] RX_dat;
    logic       OCD;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_dat;
    logic [7:0] rx_len;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    fsk_rx_frame_ctrl #(.SYNC(8'hA5), .MAX_LEN(16), .AW(4), .TO_CYC(100)) dut (
        .clk(clk), .rst(rst), .en_rx_byte(en_rx_byte), .RX_dat(RX_dat), .OCD(OCD),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat), .rx_len(rx_len), .busy(busy),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: everything the DUT emits, sampled mid-cycle.
    int mon_addr[$];
    int mon_dat[$];
    int n_ok, n_ferr, n_viol;
    bit busy_seen;

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(int'(wr_addr));
            mon_dat.push_back(int'(wr_dat));
        end
        if (frame_ok) n_ok++;
        if (frame_err) n_ferr++;
        if ((frame_ok && frame_err) || (wr_en && (frame_ok || frame_err))) n_viol++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic clear_mon();
        mon_addr.delete();
        mon_dat.delete();
        n_ok = 0;
        n_ferr = 0;
        busy_seen = 1'b0;
    endtask

    // Expected results of the current frame.
    int exp_pay[$];
    int exp_ok, exp_ferr, exp_code, exp_len;

    logic [7:0] tx_q[$];
    logic       tx_ocd[$];

    task automatic send_byte(input logic [7:0] b, input logic o, input int gap);
        @(posedge clk); #1;
        en_rx_byte = 1'b1;
        RX_dat = b;
        OCD = o;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 en_rx_byte = 1'b0;
        @(posedge clk); #1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_all();
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], tx_ocd[i], int'($urandom_range(0, 8)));
    endtask

    task automatic push(input logic [7:0] b, input logic o);
        tx_q.push_back(b);
        tx_ocd.push_back(o);
    endtask

    task automatic verify(input string tag);
        check({tag, "_nwr"}, mon_dat.size(), exp_pay.size());
        for (int i = 0; i < exp_pay.size() && i < mon_dat.size(); i++) begin
            check({tag, "_waddr"}, mon_addr[i], i);
            check({tag, "_wdat"}, mon_dat[i], exp_pay[i]);
        end
        check({tag, "_ok"}, n_ok, exp_ok);
        check({tag, "_ferr"}, n_ferr, exp_ferr);
        check({tag, "_code"}, int'(err_code), exp_code);
        check({tag, "_rxlen"}, int'(rx_len), exp_len);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Builds a well-formed frame of the given payload; checksum is LEN plus payload mod 256.
    task automatic build_frame(input int len, input bit corrupt);
        int sum;
        tx_q.delete();
        tx_ocd.delete();
        exp_pay.delete();
        push(8'hA5, 1'b1);
        push(8'(len), 1'b1);
        sum = len;
        for (int i = 0; i < len; i++) begin
            int b;
            b = ($urandom_range(0, 5) == 0) ? 8'hA5 : int'($urandom_range(0, 255));
            exp_pay.push_back(b);
            push(8'(b), 1'b1);
            sum = (sum + b) % 256;
        end
        if (corrupt) sum = sum ^ int'($urandom_range(1, 255));
        push(8'(sum), 1'b1);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        en_rx_byte = 1'b0;
        RX_dat = 8'h00;
        OCD = 1'b0;
        n_viol = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_rxlen", int'(rx_len), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_ok_err", int'({frame_ok, frame_err}), 0);
        rst = 1'b0;
        exp_len = 0;
        exp_code = 0;

        // Reference frame from the plan.
        clear_mon();
        tx_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
        tx_ocd = '{1, 1, 1, 1, 1, 1};
        send_all();
        repeat (3) @(posedge clk);
        #1;
        exp_pay = '{16, 32, 48};
        exp_ok = 1; exp_ferr = 0; exp_code = 0; exp_len = 3;
        verify("good");

        clear_mon();
        tx_q[5] = 8'h64;
        send_all();
        repeat (3) @(posedge clk);
        #1;
        exp_ok = 0; exp_ferr = 1; exp_code = 2;
        verify("badchk");

        clear_mon();
        tx_q = '{8'hA5, 8'h00};
        tx_ocd = '{1, 1};
        send_all();
        repeat (3) @(posedge clk);
        #1;
        exp_pay.delete();
        exp_ferr = 1; exp_code = 1;
        verify("len0");

        clear_mon();
        tx_q = '{8'hA5, 8'h11};
        send_all();
        repeat (3) @(posedge clk);
        #1;
        verify("len17");

        clear_mon();
        tx_q = '{8'h55, 8'hA5, 8'h03};
        tx_ocd = '{0, 0, 0};
        send_all();
        repeat (3) @(posedge clk);
        #1;
        exp_ferr = 0;
        verify("noocd");
        check("noocd_busy_seen", int'(busy_seen), 0);

        // Timeout: error lands exactly TO_CYC cycles after the last byte event.
        clear_mon();
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h02, 1'b1, 2);
        send_byte(8'h01, 1'b1, 0);
        k = 0;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); #1;
            if (frame_err) begin
                k = c;
                break;
            end
        end
        check("timeout_cycles", k, 100);
        repeat (2) @(posedge clk);
        #1;
        exp_pay = '{1};
        exp_ferr = 1; exp_code = 3; exp_len = 2;
        verify("timeout");

        // Reset in the middle of the payload.
        clear_mon();
        send_byte(8'hA5, 1'b1, 1);
        send_byte(8'h03, 1'b1, 1);
        send_byte(8'h10, 1'b1, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_rxlen", int'(rx_len), 0);
        check("midrst_code", int'(err_code), 0);
        check("midrst_wr_en", int'(wr_en), 0);
        rst = 1'b0;
        exp_len = 0; exp_code = 0;
        clear_mon();
        tx_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
        tx_ocd = '{1, 1, 1, 1, 1, 1};
        send_all();
        repeat (3) @(posedge clk);
        #1;
        exp_pay = '{16, 32, 48};
        exp_ok = 1; exp_ferr = 0; exp_len = 3;
        verify("afterrst");

        // Randomized frames against the frame-level model.
        for (int f = 0; f < 40; f++) begin
            int kind, len, n;
            kind = int'($urandom_range(0, 4));
            len = int'($urandom_range(1, 16));
            clear_mon();
            exp_ok = 0;
            exp_ferr = 0;
            case (kind)
                0, 1: begin
                    build_frame(len, kind == 1);
                    send_all();
                    repeat (3) @(posedge clk);
                    exp_ok = (kind == 0) ? 1 : 0;
                    exp_ferr = (kind == 1) ? 1 : 0;
                    exp_code = (kind == 0) ? 0 : 2;
                    exp_len = len;
                end
                2: begin
                    tx_q.delete(); tx_ocd.delete(); exp_pay.delete();
                    push(8'hA5, 1'b1);
                    push(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)), 1'b1);
                    send_all();
                    repeat (3) @(posedge clk);
                    exp_ferr = 1;
                    exp_code = 1;
                end
                3: begin
                    tx_q.delete(); tx_ocd.delete(); exp_pay.delete();
                    for (int i = 0; i < 4; i++) begin
                        if ($urandom_range(0, 1) == 0) push(8'hA5, 1'b0);
                        else push(8'($urandom_range(0, 164)), 1'($urandom_range(0, 1)));
                    end
                    send_all();
                    repeat (3) @(posedge clk);
                end
                default: begin
                    build_frame(len, 1'b0);
                    n = int'($urandom_range(1, len + 2));
                    while (tx_q.size() > n) begin
                        void'(tx_q.pop_back());
                        void'(tx_ocd.pop_back());
                    end
                    while (exp_pay.size() > ((n > 2) ? n - 2 : 0)) void'(exp_pay.pop_back());
                    send_all();
                    repeat (110) @(posedge clk);
                    exp_ferr = 1;
                    exp_code = 3;
                    if (n >= 2) exp_len = len;
                end
            endcase
            #1;
            verify($sformatf("rnd%0d_k%0d", f, kind));
        end

        check("pulse_exclusive", n_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fsk_rx_frame_ctrl.md
Name: fsk_rx_frame_ctrl

Overview:
- Frame-level receive controller behind the one-byte FSK receiver (FSK detector plus single-byte UART).
- Watches the byte receiver's `en_rx_byte` interval and `RX_dat`, then assembles frames of the form SYNC, LEN, payload[LEN], CHK.
- Writes payload bytes into an external buffer and reports frame success or failure with an error code.
- Gates frame start on the carrier-detect flag `OCD` and aborts on inter-byte timeout.

Parameters:
- SYNC, 8'hA5, frame start byte.
- MAX_LEN, 16, maximum payload length; legal LEN is 1..MAX_LEN.
- AW, 4, payload buffer address width; 2^AW >= MAX_LEN.
- TO_CYC, 500000, inter-byte timeout in clk cycles; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en_rx_byte  in  1  byte-receive interval from the byte receiver; falling edge means RX_dat is valid.
- RX_dat  in  8  received byte.
- OCD  in  1  carrier/threshold detect from the FSK detector.
- wr_en  out  1  payload buffer write strobe, one cycle.
- wr_addr  out  AW  payload write address.
- wr_dat  out  8  payload write data.
- rx_len  out  8  LEN of the current/last frame.
- busy  out  1  high whenever state is not IDLE.
- frame_ok  out  1  one-cycle pulse, frame accepted.
- frame_err  out  1  one-cycle pulse, frame rejected.
- err_code  out  2  held from the last frame_err: 1 = bad LEN, 2 = checksum mismatch, 3 = timeout; 0 after reset or frame_ok.

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high. Reset forces state IDLE and clears all outputs, counters, the checksum and en_d to 0.
- Byte event: en_d <= en_rx_byte every clk. byte_done = en_d & ~en_rx_byte (combinational). All byte handling happens on the clk edge where byte_done = 1; any resulting output is visible in the following cycle.
- FSM states: IDLE, GET_LEN, GET_DATA, GET_CHK.
  - IDLE: on byte_done with RX_dat == SYNC and OCD == 1, go to GET_LEN and clear the timer. Any other byte is ignored.
  - GET_LEN:
    - If byte value is 0 or > MAX_LEN: frame_err = 1, err_code = 1, go to IDLE.
    - Otherwise: rx_len <= byte, sum <= byte, idx <= 0, go to GET_DATA.
  - GET_DATA: on each byte_done, assert wr_en for one cycle with wr_addr = idx[AW-1:0] and wr_dat = byte. Then idx++ and sum <= sum + byte (mod 256). When idx reaches rx_len-1 on this byte, go to GET_CHK.
  - GET_CHK:
    - If byte == sum: frame_ok = 1, err_code = 0.
    - Otherwise: frame_err = 1, err_code = 2.
    - Either way, go to IDLE.
- Timeout:
  - The timer counts clk cycles in every non-IDLE state and clears on each byte_done.
  - When the timer reaches TO_CYC-1 with no byte_done in that cycle: frame_err = 1, err_code = 3, go to IDLE.
  - If byte_done coincides with the terminal count, the byte is processed and the timer clears (byte wins).
  - Payload already written is not rolled back; the consumer must wait for frame_ok.
- OCD is checked only for the SYNC byte. Carrier loss mid-frame is caught by timeout or checksum.
- frame_ok and frame_err are never high in the same cycle. wr_en and frame pulses are never high in the same cycle.
- rx_len holds its value until the next accepted LEN.
- A SYNC-valued byte inside a frame is treated as data; there is no resync mid-frame.
- Back-to-back frames: a SYNC arriving on the first byte_done after IDLE re-entry is accepted.

Test Plan:
- Frame A5, 03, 10, 20, 30, 63 with OCD=1:
  - 3 wr_en pulses: addr 0/1/2, data 10/20/30.
  - Then frame_ok=1, err_code=0, rx_len=3.
- Same frame with CHK=64: 3 writes, then frame_err=1 with err_code=2, no frame_ok.
- Bad LEN:
  - A5, 00 -> frame_err with err_code=1, no writes.
  - A5, 11 (17 > MAX_LEN) -> same response.
- Bytes 55, A5 with OCD=0, then 03 -> all ignored; busy stays 0.
- Timeout (TO_CYC=100 for sim): A5, 02, 01, then silence -> frame_err with err_code=3 exactly 100 clk after the last byte_done. busy=0 after.
- rst=1 asserted mid-GET_DATA:
  - Next cycle: outputs 0, state IDLE.
  - A following full valid frame is received correctly with frame_ok=1.
